// File: rtl/bridge_pkg.sv
// Shared types and protocol constants for the UART-to-bus debug bridge.
package bridge_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    DATA,
    BUS_WR,
    BUS_RD,
    RD_WAIT,
    RESP
  } state_t;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;

endpackage

// File: rtl/bridge_timeout.sv
// Inter-byte timeout: counts while a command is partially received, restarts on every consumed byte.
module bridge_timeout #(
  parameter int TIMEOUT_CYCLES = 12000
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic clear,
  output logic expired
);

  localparam int W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] LIMIT = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (!run || clear) begin
      count <= '0;
    end else if (!expired) begin
      count <= count + W'(1);
    end
  end

  // Independent of clear so the bridge can gate byte capture with it without a loop.
  assign expired = run && (count == LIMIT);

endmodule

// File: rtl/uart_bus_bridge.sv
// UART command stream to single-word bus reads/writes; optional inter-byte timeout under BRIDGE_TIMEOUT_EN.
module uart_bus_bridge
  import bridge_pkg::*;
#(
  parameter int FREQ_MHZ       = 12,
  parameter int TIMEOUT_CYCLES = FREQ_MHZ * 1000
) (
  input  logic        clk,
  input  logic        reset_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_rd_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_wr_o,
  input  logic        tx_busy_i,
  output logic        bus_req_o,
  output logic [31:0] addr_o,
  output logic        we_o,
  output logic [3:0]  wr_mask_o,
  output logic [31:0] data_out_o,
  input  logic [31:0] data_in_i
);

  state_t      state, state_n;
  logic [1:0]  cnt;
  logic [1:0]  rx_hold;
  logic [1:0]  tx_hold;
  logic        is_write;
  logic [31:0] addr;
  logic [31:0] data;
  logic [31:0] resp;
  logic        take;
  logic        send;
  logic        timeout;
  logic        collect_run;

  assign collect_run = (state == ADDR) || (state == DATA);

`ifdef BRIDGE_TIMEOUT_EN
  bridge_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (reset_i),
    .run    (collect_run),
    .clear  (take),
    .expired(timeout)
  );
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^{collect_run, TIMEOUT_CYCLES};
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_n = state;
    take    = 1'b0;
    send    = 1'b0;
    if ((state == IDLE || state == ADDR || state == DATA) &&
        rx_valid_i && (rx_hold == 2'd0) && !timeout) begin
      take = 1'b1;
    end
    if ((state == RESP) && (tx_hold == 2'd0) && !tx_busy_i) begin
      send = 1'b1;
    end
    case (state)
      IDLE: begin
        if (take && (rx_data_i == CMD_WRITE || rx_data_i == CMD_READ)) state_n = ADDR;
      end
      ADDR: begin
        if (timeout) state_n = IDLE;
        else if (take && cnt == 2'd3) state_n = is_write ? DATA : BUS_RD;
      end
      DATA: begin
        if (timeout) state_n = IDLE;
        else if (take && cnt == 2'd3) state_n = BUS_WR;
      end
      BUS_WR:  state_n = RESP;
      BUS_RD:  state_n = RD_WAIT;
      RD_WAIT: state_n = RESP;
      RESP: begin
        if (send && (is_write || cnt == 2'd3)) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state     <= IDLE;
      cnt       <= 2'd0;
      rx_hold   <= 2'd0;
      tx_hold   <= 2'd0;
      is_write  <= 1'b0;
      addr      <= 32'h0;
      data      <= 32'h0;
      resp      <= 32'h0;
      tx_wr_o   <= 1'b0;
      tx_data_o <= 8'h00;
    end else begin
      state   <= state_n;
      tx_wr_o <= send;
      // The SoC registers rd and busy, so both flags are stale for a couple of cycles.
      if (take) rx_hold <= 2'd2;
      else if (rx_hold != 2'd0) rx_hold <= rx_hold - 2'd1;
      if (send) tx_hold <= 2'd3;
      else if (tx_hold != 2'd0) tx_hold <= tx_hold - 2'd1;
      if (send) begin
        tx_data_o <= resp[7:0];
        resp      <= {8'h00, resp[31:8]};
        cnt       <= cnt + 2'd1;
      end
      case (state)
        IDLE: begin
          if (take) begin
            is_write <= (rx_data_i == CMD_WRITE);
            cnt      <= 2'd0;
          end
        end
        ADDR: begin
          if (take) begin
            addr <= {rx_data_i, addr[31:8]};
            cnt  <= cnt + 2'd1;
          end
        end
        DATA: begin
          if (take) begin
            data <= {rx_data_i, data[31:8]};
            cnt  <= cnt + 2'd1;
          end
        end
        BUS_WR: begin
          resp <= {24'h0, RSP_ACK};
          cnt  <= 2'd0;
        end
        RD_WAIT: begin
          resp <= data_in_i;
          cnt  <= 2'd0;
        end
        default: ;
      endcase
    end
  end

  assign rx_rd_o    = take & ~reset_i;
  assign bus_req_o  = (state != IDLE);
  assign we_o       = (state == BUS_WR);
  assign wr_mask_o  = {4{we_o}};
  assign addr_o     = addr;
  assign data_out_o = data;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: UART/memory environment plus a transaction-level reference model.
module tb_uart_bus_bridge;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [7:0]  rx_data_i;
  logic        rx_valid_i;
  logic        rx_rd_o;
  logic [7:0]  tx_data_o;
  logic        tx_wr_o;
  logic        tx_busy_i;
  logic        bus_req_o;
  logic [31:0] addr_o;
  logic        we_o;
  logic [3:0]  wr_mask_o;
  logic [31:0] data_out_o;
  logic [31:0] data_in_i;

  always #5 clk = ~clk;

  uart_bus_bridge #(.FREQ_MHZ(12), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset_i(reset_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_rd_o(rx_rd_o),
    .tx_data_o(tx_data_o), .tx_wr_o(tx_wr_o), .tx_busy_i(tx_busy_i),
    .bus_req_o(bus_req_o), .addr_o(addr_o), .we_o(we_o), .wr_mask_o(wr_mask_o),
    .data_out_o(data_out_o), .data_in_i(data_in_i)
  );

  int passed = 0;
  int total  = 0;

  logic [7:0]  rx_q[$];
  logic [7:0]  tx_got[$];
  logic [31:0] env_mem [logic [29:0]];
  logic [31:0] ref_mem [logic [29:0]];
  int rd_cnt = 0, we_cnt = 0, bus_seen = 0, mask_err = 0, busy_left = 0;
  bit force_busy = 1'b0;
  logic [31:0] wr_addr = 0, wr_data = 0, rd_addr = 0;
  logic [3:0]  wr_mask = 0;

  function automatic logic [31:0] pre(input logic [29:0] w);
    return {w[13:0], w[17:0]} ^ 32'h5A3C_96E1;
  endfunction
  function automatic logic [31:0] env_rd(input logic [29:0] w);
    return env_mem.exists(w) ? env_mem[w] : pre(w);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a[31:2]) ? ref_mem[a[31:2]] : pre(a[31:2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // UART + synchronous memory environment: sample on the rising edge, drive 1 ns later.
  initial begin
    rx_valid_i = 1'b0; rx_data_i = 8'h00; tx_busy_i = 1'b0; data_in_i = 32'h0;
    forever begin
      @(posedge clk);
      if (!reset_i) begin
        if (rx_rd_o) begin
          rd_cnt++;
          if (rx_q.size() > 0) void'(rx_q.pop_front());
        end
        if (we_o) begin
          we_cnt++;
          wr_addr = addr_o; wr_data = data_out_o; wr_mask = wr_mask_o;
          env_mem[addr_o[31:2]] = data_out_o;
        end
        if (wr_mask_o !== {4{we_o}}) mask_err++;
        if (tx_wr_o) begin
          tx_got.push_back(tx_data_o);
          busy_left = $urandom_range(3, 9);
        end else if (busy_left > 0) begin
          busy_left--;
        end
        if (bus_req_o) bus_seen++;
        rd_addr = addr_o;
      end
      #1;
      data_in_i  = env_rd(rd_addr[31:2]);
      tx_busy_i  = force_busy || (busy_left > 0);
      rx_valid_i = (rx_q.size() > 0);
      rx_data_i  = (rx_q.size() > 0) ? rx_q[0] : 8'h00;
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_bus_req"}, 32'(bus_req_o), 0);
    check({tag, "_we"}, 32'(we_o), 0);
    check({tag, "_mask"}, 32'(wr_mask_o), 0);
    check({tag, "_addr"}, addr_o, 0);
    check({tag, "_dout"}, data_out_o, 0);
    check({tag, "_tx_wr"}, 32'(tx_wr_o), 0);
    check({tag, "_tx_data"}, 32'(tx_data_o), 0);
    check({tag, "_rx_rd"}, 32'(rx_rd_o), 0);
  endtask

  task automatic wait_idle(input int n_tx, input string tag);
    bit done = 1'b0;
    for (int c = 0; c < 4000 && !done; c++) begin
      @(negedge clk);
      if (rx_q.size() == 0 && tx_got.size() >= n_tx && bus_req_o == 1'b0) done = 1'b1;
    end
    check({tag, "_done"}, 32'(done), 1);
    repeat (6) @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 reset_i = 1'b1;
    rx_q.delete();
    repeat (3) @(negedge clk);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // Queue one command, derive the expected outcome from the protocol rules, compare.
  task automatic txn(input logic [7:0] cmd, input logic [31:0] a, input logic [31:0] d, input string tag);
    int rd0, we0, bs0, n_bytes, n_tx;
    logic [31:0] exp_word;
    rd0 = rd_cnt; we0 = we_cnt; bs0 = bus_seen;
    tx_got.delete();
    rx_q.push_back(cmd);
    n_bytes = 1; n_tx = 0; exp_word = 32'h0;
    if (cmd == 8'h57 || cmd == 8'h52) begin
      for (int i = 0; i < 4; i++) rx_q.push_back(a[8*i +: 8]);
      n_bytes = 5;
    end
    if (cmd == 8'h57) begin
      for (int i = 0; i < 4; i++) rx_q.push_back(d[8*i +: 8]);
      n_bytes = 9; n_tx = 1; exp_word = 32'h4B;
      ref_mem[a[31:2]] = d;
    end else if (cmd == 8'h52) begin
      n_tx = 4; exp_word = ref_rd(a);
    end
    wait_idle(n_tx, tag);
    check({tag, "_rx_rd_cnt"}, 32'(rd_cnt - rd0), 32'(n_bytes));
    check({tag, "_we_cnt"}, 32'(we_cnt - we0), (cmd == 8'h57) ? 32'd1 : 32'd0);
    check({tag, "_tx_cnt"}, 32'(tx_got.size()), 32'(n_tx));
    for (int i = 0; i < n_tx && i < tx_got.size(); i++)
      check($sformatf("%s_tx%0d", tag, i), 32'(tx_got[i]), 32'(exp_word[8*i +: 8]));
    if (cmd == 8'h57) begin
      check({tag, "_wr_addr"}, wr_addr, a);
      check({tag, "_wr_data"}, wr_data, d);
      check({tag, "_wr_mask"}, 32'(wr_mask), 32'hF);
    end
    if (cmd != 8'h57 && cmd != 8'h52) check({tag, "_no_bus_req"}, 32'(bus_seen - bs0), 0);
    check({tag, "_bus_req_end"}, 32'(bus_req_o), 0);
  endtask

  initial begin
    int rd0, we0, n0, r;
    bit got;
    logic [7:0] cmd;
    reset_i = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    reset_i = 1'b0;
    repeat (2) @(negedge clk);

    // Read 0x100 with backpressure and a trailing byte that must wait in the UART.
    env_mem[30'h40] = 32'hCAFE_F00D;
    ref_mem[30'h40] = 32'hCAFE_F00D;
    rd0 = rd_cnt; we0 = we_cnt; tx_got.delete();
    rx_q = '{8'h52, 8'h00, 8'h01, 8'h00, 8'h00, 8'h41};
    got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (tx_got.size() >= 1) got = 1'b1;
    end
    check("rd_first_tx", 32'(got), 1);
    check("rd_no_rx_in_resp", 32'(rd_cnt - rd0), 5);
    force_busy = 1'b1;
    repeat (2) @(negedge clk);
    n0 = tx_got.size();
    repeat (48) @(negedge clk);
    check("rd_no_tx_while_busy", 32'(tx_got.size()), 32'(n0));
    check("rd_byte_pending", 32'(rx_q.size()), 1);
    force_busy = 1'b0;
    wait_idle(4, "rd_bp");
    for (int i = 0; i < 4 && i < tx_got.size(); i++)
      check($sformatf("rd_bp_tx%0d", i), 32'(tx_got[i]), 32'(ref_rd(32'h100) >> (8 * i)) & 32'hFF);
    check("rd_bp_no_we", 32'(we_cnt - we0), 0);
    check("rd_bp_rx_total", 32'(rd_cnt - rd0), 6);

    txn(8'h57, 32'h0000_0100, 32'hDEAD_BEEF, "wr100");
    txn(8'h41, 32'h0, 32'h0, "unknown");
    txn(8'h52, 32'h0000_0100, 32'h0, "rd100_after_wr");

    for (int k = 0; k < 8; k++) begin
      r = $urandom_range(0, 9);
      cmd = (r < 4) ? 8'h57 : (r < 8) ? 8'h52 : 8'(8'h30 + r);
      txn(cmd, 32'h200 + 32'($urandom_range(0, 31)), $urandom, $sformatf("rand%0d", k));
    end

    // Truncated write: timeout discards it, otherwise it waits in ADDR.
    we0 = we_cnt;
    rx_q = '{8'h57, 8'h01};
    repeat (10000) @(negedge clk);
`ifdef BRIDGE_TIMEOUT_EN
    check("timeout_idle", 32'(bus_req_o), 0);
    check("timeout_no_we", 32'(we_cnt - we0), 0);
`else
    check("no_timeout_holds", 32'(bus_req_o), 1);
    check("no_timeout_no_we", 32'(we_cnt - we0), 0);
    do_reset();
`endif
    txn(8'h57, 32'h0000_0120, 32'h1234_5678, "after_timeout_wr");

    // Asynchronous reset in the middle of the data field.
    rd0 = rd_cnt; we0 = we_cnt;
    rx_q = '{8'h57, 8'h44, 8'h03, 8'h00, 8'h00, 8'h11, 8'h22};
    got = 1'b0;
    for (int c = 0; c < 500 && !got; c++) begin
      @(negedge clk);
      if (rd_cnt - rd0 >= 7) got = 1'b1;
    end
    check("mid_data_reached", 32'(got), 1);
    repeat (3) @(posedge clk);
    #3 reset_i = 1'b1;
    #1 check_zero("async_rst");
    rx_q.delete();
    repeat (5) @(negedge clk);
    check("async_rst_no_we", 32'(we_cnt - we0), 0);
    reset_i = 1'b0;
    repeat (2) @(negedge clk);
    txn(8'h52, 32'h0000_0344, 32'h0, "post_rst_rd");
    txn(8'h57, 32'h0000_0344, 32'hA5A5_0F0F, "post_rst_wr");
    txn(8'h52, 32'h0000_0344, 32'h0, "post_rst_rdback");

    check("mask_matches_we", 32'(mask_err), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
